cci_mem_responder: RTL and testbench
====================================

Name: cci_mem_responder

Overview:
- Synthesizable CCI-S responder model: the target end of the AFU CCI request interface that the ASE transaction logger monitors.
- Accepts TX0 read and TX1 write/fence requests, backs them with a local line memory, and returns RX0 read responses and RX1 write responses with programmable latency.
- Used in ASE self-test benches and standalone AFU unit sims in place of the DPI memory path.

Parameters:
- DEPTH, 256, number of 512-bit lines in local memory; power of two; index = addr[$clog2(DEPTH)-1:0], upper address bits alias.
- READ_LAT, 8, cycles from TX0 accept to RX0 rdvalid; valid range 2..255.
- WRITE_LAT, 4, cycles from TX1 accept to RX1 wrvalid; valid range 2..255.
- MAX_OUTSTANDING, 16, depth of each response FIFO; power of two.
- AF_MARGIN, 4, almostfull asserts when occupancy >= MAX_OUTSTANDING-AF_MARGIN.

Ports:
- clk  in  1  clock
- sys_reset  in  1  synchronous active-high reset
- lp_initdone  out  1  0 in reset; 1 from the first cycle after reset deasserts
- tx_c0_header  in  61  [55:52] type, [45:14] line address, [13:0] mdata
- tx_c0_rdvalid  in  1  read request strobe
- tx_c0_almostfull  out  1  read FIFO near full
- tx_c1_header  in  61  same layout as tx_c0_header
- tx_c1_data  in  512  write data
- tx_c1_wrvalid  in  1  write/fence request strobe
- tx_c1_almostfull  out  1  write FIFO near full
- rx_c0_header  out  18  [13:0] mdata, [17:14] = 4'h4 (read response type)
- rx_c0_data  out  512  read data
- rx_c0_rdvalid  out  1  read response strobe
- rx_c1_header  out  18  [13:0] mdata, [17:14] = 4'h1 (write response type)
- rx_c1_wrvalid  out  1  write response strobe
- err_flags  out  4  sticky: [0] rd overflow, [1] wr overflow, [2] unknown tx0 type, [3] unknown tx1 type

Behaviour:
- Reset: all outputs 0, FIFOs empty, cycle counter 0, err_flags 0. Memory contents are not reset.
- Requests are ignored while sys_reset is high or lp_initdone is 0.
- Reset asserted mid-operation flushes all FIFOs; in-flight responses are lost, with no partial response.
- Cycle counter: 16-bit free-running `now`, wraps at 0xFFFF->0.
- TX0 accept (rdvalid, type RdLine_S 4'h4 / RdLine_I 4'h6 / RdLine_O 4'h7):
  - memory read at index in the accept cycle;
  - push {mdata, data, due = now+READ_LAT} to rd FIFO.
- TX1 accept:
  - WrThru 4'h1 / WrLine 4'h2: memory write in the accept cycle, push {mdata, due = now+WRITE_LAT} to wr FIFO.
  - WrFence 4'h5: no memory write; pushes a wr FIFO entry, so its response follows all earlier writes in order.
- Same-cycle TX0 read and TX1 write to the same index: the read returns OLD data (read-before-write).
- Unknown type: request dropped, no response, corresponding err bit set.
- Pop rule, each FIFO independently, max one pop per cycle:
  - head pops when FIFO is nonempty and signed 16-bit (now - due) >= 0;
  - the compare must be correct across the counter wrap.
- Response timing: a pop registers the rx header/data; the strobe is high exactly one cycle, at accept cycle + LAT.
- Back-to-back requests produce back-to-back responses, order preserved per channel.
- Full FIFO plus new request: request dropped, overflow err bit set sticky.
- A simultaneous pop and push on a full FIFO is accepted.
- almostfull is combinational from occupancy; it is advisory only.

Optional Feature:
- CCI_RESP_RANDOM_DELAY_EN defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) adds lfsr[2:0] (0..7) extra cycles to each due value;
  - one LFSR step per accepted request, TX0 first when both channels accept in the same cycle;
  - per-channel response order is still preserved (head-of-line).
- Not defined: latency is exactly READ_LAT / WRITE_LAT.

Decomposition:
- Package cci_resp_pkg holds:
  - the type-code localparams (RDLINE_S/I/O, WRTHRU, WRLINE, WRFENCE, RSP_RD, RSP_WR);
  - the header bit-range localparams;
  - typedef rd_entry_t {mdata, data, due};
  - typedef wr_entry_t {mdata, due}.
- One sub-module, cci_resp_fifo: parameterized-width sync FIFO with count output, instantiated twice. Memory is an inferred array in the top level.

Test Plan:
- Write then read: WrLine addr 0x10, data {16{32'hDEADBEEF}}, mdata 0x5 at t0 -> rx_c1_wrvalid at t0+4 with mdata 0x5. RdLine_S addr 0x10, mdata 0x9 at t0+10 -> rx_c0_rdvalid at t0+18 with data DEADBEEF pattern and mdata 0x9.
- Same-cycle hazard: line 0x20 holds all-0. RdLine_I and WrLine all-1 to 0x20 in the same cycle -> read returns all-0. A later read returns all-1.
- Fence ordering: WrLine m=1, WrLine m=2, WrFence m=3 on consecutive cycles -> rx_c1 mdata 1,2,3 on consecutive cycles starting at first accept +4.
- Overflow: with RANDOM_DELAY forcing backlog, issue 17 reads while ignoring almostfull:
  - almostfull high at occupancy 12;
  - 17th read dropped when the FIFO is full with no pop in that cycle;
  - err_flags[0] = 1;
  - exactly 16 responses.
- Wrap-around: run until now = 0xFFFA, issue a read -> response exactly 8 cycles later at now = 0x0002.
- Reset mid-flight / bad type: assert sys_reset 1 cycle with 3 reads pending -> no rx strobes afterwards, lp_initdone 0 then 1. Then type 4'hF on TX1 -> no response, err_flags[3] = 1.

Source files
------------

// File: rtl/cci_resp_pkg.sv
// cci_resp_pkg: shared definitions for the CCI-S responder model.
//   - request/response type codes carried in the CCI headers
//   - bit ranges of the 61-bit TX headers
//   - response FIFO entry layouts and small decode/timing helpers
package cci_resp_pkg;

   localparam logic [3:0] RDLINE_S = 4'h4;
   localparam logic [3:0] RDLINE_I = 4'h6;
   localparam logic [3:0] RDLINE_O = 4'h7;
   localparam logic [3:0] WRTHRU   = 4'h1;
   localparam logic [3:0] WRLINE   = 4'h2;
   localparam logic [3:0] WRFENCE  = 4'h5;
   localparam logic [3:0] RSP_RD   = 4'h4;
   localparam logic [3:0] RSP_WR   = 4'h1;

   localparam int unsigned HDR_TYPE_HI  = 55;
   localparam int unsigned HDR_TYPE_LO  = 52;
   localparam int unsigned HDR_ADDR_HI  = 45;
   localparam int unsigned HDR_ADDR_LO  = 14;
   localparam int unsigned HDR_MDATA_HI = 13;
   localparam int unsigned HDR_MDATA_LO = 0;

   typedef struct packed {
      logic [13:0]  mdata;
      logic [511:0] data;
      logic [15:0]  due;
   } rd_entry_t;

   typedef struct packed {
      logic [13:0] mdata;
      logic [15:0] due;
   } wr_entry_t;

   function automatic logic is_rd_type(input logic [3:0] t);
      return (t == RDLINE_S) || (t == RDLINE_I) || (t == RDLINE_O);
   endfunction

   function automatic logic is_wr_type(input logic [3:0] t);
      return (t == WRTHRU) || (t == WRLINE);
   endfunction

   // Signed 16-bit distance so the test stays correct across counter wrap.
   function automatic logic due_reached(input logic [15:0] now_v, input logic [15:0] due);
      logic [15:0] diff;
      diff = now_v - due;
      return !diff[15];
   endfunction

   // Fibonacci LFSR, taps 16,14,13,11.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/cci_resp_fifo.sv
// cci_resp_fifo: synchronous FIFO with occupancy count.
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write one entry (ignored when full unless popping)
//   pop, head       head entry is visible on head; pop advances it
//   empty, full     status flags
//   count           occupancy, 0..DEPTH
module cci_resp_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/cci_mem_responder.sv
// cci_mem_responder: CCI-S responder model backed by a local line memory.
//   clk, sys_reset      clock, synchronous active-high reset
//   lp_initdone         high from the first cycle after reset
//   tx_c0_*             read requests in, almostfull out
//   tx_c1_*             write/fence requests in, almostfull out
//   rx_c0_*             read responses (header, data, one-cycle strobe)
//   rx_c1_*             write responses (header, one-cycle strobe)
//   err_flags           sticky: rd overflow, wr overflow, bad tx0 type, bad tx1 type
// Build option: CCI_RESP_RANDOM_DELAY_EN adds 0..7 LFSR cycles to each due time.
module cci_mem_responder #(
   parameter int unsigned DEPTH           = 256,
   parameter int unsigned READ_LAT        = 8,
   parameter int unsigned WRITE_LAT       = 4,
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter int unsigned AF_MARGIN       = 4
) (
   input  logic         clk,
   input  logic         sys_reset,
   output logic         lp_initdone,
   input  logic [60:0]  tx_c0_header,
   input  logic         tx_c0_rdvalid,
   output logic         tx_c0_almostfull,
   input  logic [60:0]  tx_c1_header,
   input  logic [511:0] tx_c1_data,
   input  logic         tx_c1_wrvalid,
   output logic         tx_c1_almostfull,
   output logic [17:0]  rx_c0_header,
   output logic [511:0] rx_c0_data,
   output logic         rx_c0_rdvalid,
   output logic [17:0]  rx_c1_header,
   output logic         rx_c1_wrvalid,
   output logic [3:0]   err_flags
);
   import cci_resp_pkg::*;

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [511:0]     mem [DEPTH];
   logic [15:0]      now;
   logic [15:0]      now_nxt;
   logic             live;

   logic [3:0]       c0_type, c1_type;
   logic [IDX_W-1:0] c0_idx, c1_idx;
   logic             c0_ok, c0_bad, c1_ok, c1_bad, c1_write;
   logic             rd_push, wr_push, rd_pop, wr_pop, rd_ovf, wr_ovf;
   logic             rd_empty, rd_full, wr_empty, wr_full;
   logic [CNT_W-1:0] rd_count, wr_count;
   logic [2:0]       rd_extra, wr_extra;
   rd_entry_t        rd_in, rd_head;
   wr_entry_t        wr_in, wr_head;
   logic             unused_hdr;

   assign unused_hdr = ^{tx_c0_header, tx_c1_header};

   assign live    = !sys_reset && lp_initdone;
   assign now_nxt = now + 16'd1;

   assign c0_type  = tx_c0_header[HDR_TYPE_HI:HDR_TYPE_LO];
   assign c1_type  = tx_c1_header[HDR_TYPE_HI:HDR_TYPE_LO];
   assign c0_idx   = tx_c0_header[HDR_ADDR_LO +: IDX_W];
   assign c1_idx   = tx_c1_header[HDR_ADDR_LO +: IDX_W];
   assign c1_write = is_wr_type(c1_type);

   assign c0_ok  = live && tx_c0_rdvalid && is_rd_type(c0_type);
   assign c0_bad = live && tx_c0_rdvalid && !is_rd_type(c0_type);
   assign c1_ok  = live && tx_c1_wrvalid && (c1_write || (c1_type == WRFENCE));
   assign c1_bad = live && tx_c1_wrvalid && !(c1_write || (c1_type == WRFENCE));

   // Pop decision made one cycle early: the registered strobe lands on due.
   assign rd_pop = !rd_empty && due_reached(now_nxt, rd_head.due);
   assign wr_pop = !wr_empty && due_reached(now_nxt, wr_head.due);

   assign rd_push = c0_ok && (!rd_full || rd_pop);
   assign rd_ovf  = c0_ok && rd_full && !rd_pop;
   assign wr_push = c1_ok && (!wr_full || wr_pop);
   assign wr_ovf  = c1_ok && wr_full && !wr_pop;

`ifdef CCI_RESP_RANDOM_DELAY_EN
   logic [15:0] lfsr, lfsr_mid;

   // TX0 consumes the current state; TX1 sees the state after TX0's step.
   always_comb begin
      rd_extra = rd_push ? lfsr[2:0] : 3'd0;
      lfsr_mid = rd_push ? lfsr_next(lfsr) : lfsr;
      wr_extra = wr_push ? lfsr_mid[2:0] : 3'd0;
   end

   always_ff @(posedge clk) begin
      if (sys_reset)    lfsr <= 16'hACE1;
      else if (wr_push) lfsr <= lfsr_next(lfsr_mid);
      else              lfsr <= lfsr_mid;
   end
`else
   assign rd_extra = 3'd0;
   assign wr_extra = 3'd0;
`endif

   always_comb begin
      rd_in       = '0;
      rd_in.mdata = tx_c0_header[HDR_MDATA_HI:HDR_MDATA_LO];
      rd_in.data  = mem[c0_idx];
      rd_in.due   = now + 16'(READ_LAT) + {13'd0, rd_extra};
      wr_in       = '0;
      wr_in.mdata = tx_c1_header[HDR_MDATA_HI:HDR_MDATA_LO];
      wr_in.due   = now + 16'(WRITE_LAT) + {13'd0, wr_extra};
   end

   // Read data is sampled combinationally above, so a same-cycle write
   // to the same line is seen by later reads only.
   always_ff @(posedge clk) begin
      if (wr_push && c1_write) mem[c1_idx] <= tx_c1_data;
   end

   cci_resp_fifo #(.WIDTH($bits(rd_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
      .clk       (clk),
      .rst       (sys_reset),
      .push      (rd_push),
      .push_data (rd_in),
      .pop       (rd_pop),
      .head      (rd_head),
      .empty     (rd_empty),
      .full      (rd_full),
      .count     (rd_count)
   );

   cci_resp_fifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_wr_fifo (
      .clk       (clk),
      .rst       (sys_reset),
      .push      (wr_push),
      .push_data (wr_in),
      .pop       (wr_pop),
      .head      (wr_head),
      .empty     (wr_empty),
      .full      (wr_full),
      .count     (wr_count)
   );

   assign tx_c0_almostfull = (rd_count >= CNT_W'(MAX_OUTSTANDING - AF_MARGIN));
   assign tx_c1_almostfull = (wr_count >= CNT_W'(MAX_OUTSTANDING - AF_MARGIN));

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         now           <= '0;
         lp_initdone   <= 1'b0;
         rx_c0_header  <= '0;
         rx_c0_data    <= '0;
         rx_c0_rdvalid <= 1'b0;
         rx_c1_header  <= '0;
         rx_c1_wrvalid <= 1'b0;
         err_flags     <= '0;
      end else begin
         now           <= now_nxt;
         lp_initdone   <= 1'b1;
         rx_c0_rdvalid <= rd_pop;
         rx_c1_wrvalid <= wr_pop;
         if (rd_pop) begin
            rx_c0_header <= {RSP_RD, rd_head.mdata};
            rx_c0_data   <= rd_head.data;
         end
         if (wr_pop) rx_c1_header <= {RSP_WR, wr_head.mdata};
         err_flags <= err_flags | {c1_bad, c0_bad, wr_ovf, rd_ovf};
      end
   end

endmodule

// File: tb/tb_cci_mem_responder.sv
// tb_cci_mem_responder: directed bench for cci_mem_responder.
// A default-parameter instance covers latency, hazards, ordering, wrap and
// reset; a second instance with a long read latency builds up a backlog to
// exercise almostfull and overflow.
module tb_cci_mem_responder;

   logic         clk = 1'b0;
   logic         sys_reset;
   logic         lp_initdone;
   logic [60:0]  tx_c0_header, tx_c1_header;
   logic         tx_c0_rdvalid, tx_c1_wrvalid;
   logic [511:0] tx_c1_data;
   logic         tx_c0_almostfull, tx_c1_almostfull;
   logic [17:0]  rx_c0_header, rx_c1_header;
   logic [511:0] rx_c0_data;
   logic         rx_c0_rdvalid, rx_c1_wrvalid;
   logic [3:0]   err_flags;

   logic [60:0]  ov_c0_header;
   logic         ov_c0_rdvalid;
   logic [60:0]  ov_c1_header = '0;
   logic [511:0] ov_c1_data   = '0;
   logic         ov_c1_wrvalid = 1'b0;
   logic         ov_initdone, ov_c0_af, ov_c1_af, ov_rdvalid, ov_wrvalid;
   logic [17:0]  ov_rx0_hdr, ov_rx1_hdr;
   logic [511:0] ov_rx0_data;
   logic [3:0]   ov_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rd_cnt  = 0;
   int wr_cnt  = 0;
   int ov_cnt  = 0;
   int ov_bad  = 0;

   localparam logic [511:0] DB  = {16{32'hDEADBEEF}};
   localparam logic [511:0] PAT = {16{32'h12345678}};

   always #5 clk = ~clk;

   cci_mem_responder dut (
      .clk(clk), .sys_reset(sys_reset), .lp_initdone(lp_initdone),
      .tx_c0_header(tx_c0_header), .tx_c0_rdvalid(tx_c0_rdvalid),
      .tx_c0_almostfull(tx_c0_almostfull),
      .tx_c1_header(tx_c1_header), .tx_c1_data(tx_c1_data),
      .tx_c1_wrvalid(tx_c1_wrvalid), .tx_c1_almostfull(tx_c1_almostfull),
      .rx_c0_header(rx_c0_header), .rx_c0_data(rx_c0_data),
      .rx_c0_rdvalid(rx_c0_rdvalid), .rx_c1_header(rx_c1_header),
      .rx_c1_wrvalid(rx_c1_wrvalid), .err_flags(err_flags)
   );

   cci_mem_responder #(.READ_LAT(40)) dut_ov (
      .clk(clk), .sys_reset(sys_reset), .lp_initdone(ov_initdone),
      .tx_c0_header(ov_c0_header), .tx_c0_rdvalid(ov_c0_rdvalid),
      .tx_c0_almostfull(ov_c0_af),
      .tx_c1_header(ov_c1_header), .tx_c1_data(ov_c1_data),
      .tx_c1_wrvalid(ov_c1_wrvalid), .tx_c1_almostfull(ov_c1_af),
      .rx_c0_header(ov_rx0_hdr), .rx_c0_data(ov_rx0_data),
      .rx_c0_rdvalid(ov_rdvalid), .rx_c1_header(ov_rx1_hdr),
      .rx_c1_wrvalid(ov_wrvalid), .err_flags(ov_err)
   );

   // Response counters; the overflow instance expects mdata 0..15 then 0x77.
   always @(negedge clk) begin
      if (rx_c0_rdvalid) rd_cnt++;
      if (rx_c1_wrvalid) wr_cnt++;
      if (ov_rdvalid) begin
         if (ov_rx0_hdr !== {4'h4, (ov_cnt < 16) ? 14'(ov_cnt) : 14'h77}) ov_bad++;
         ov_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [60:0] mk_hdr(input logic [3:0] t, input logic [31:0] a,
                                          input logic [13:0] m);
      logic [60:0] h;
      h = '0;
      h[55:52] = t;
      h[45:14] = a;
      h[13:0]  = m;
      return h;
   endfunction

   task automatic drive_rd(input logic [3:0] t, input logic [31:0] a, input logic [13:0] m);
      tx_c0_header  = mk_hdr(t, a, m);
      tx_c0_rdvalid = 1'b1;
   endtask

   task automatic drive_wr(input logic [3:0] t, input logic [31:0] a, input logic [13:0] m,
                           input logic [511:0] d);
      tx_c1_header  = mk_hdr(t, a, m);
      tx_c1_data    = d;
      tx_c1_wrvalid = 1'b1;
   endtask

   task automatic idle();
      tx_c0_rdvalid = 1'b0;
      tx_c1_wrvalid = 1'b0;
   endtask

   initial begin
      int rc0, wc0;
      sys_reset = 1'b1;
      tx_c0_header = '0; tx_c1_header = '0; tx_c1_data = '0;
      tx_c0_rdvalid = 1'b0; tx_c1_wrvalid = 1'b0;
      ov_c0_header = '0; ov_c0_rdvalid = 1'b0;

      tick(); tick(); cyc = 0;
      chk("rst_initdone", lp_initdone, 0);
      chk("rst_rdvalid", rx_c0_rdvalid, 0);
      chk("rst_wrvalid", rx_c1_wrvalid, 0);
      chk("rst_err", err_flags, 0);
      chk("rst_af", tx_c0_almostfull, 0);
      sys_reset = 1'b0;
      tick();
      chk("initdone_up", lp_initdone, 1);

      // Write then read back
      drive_wr(4'h2, 32'h10, 14'h5, DB); tick(); idle();
      repeat (2) tick();
      chk("wr_early", rx_c1_wrvalid, 0);
      tick();
      chk("wr_rsp_valid", rx_c1_wrvalid, 1);
      chk("wr_rsp_hdr", rx_c1_header, 18'h04005);
      tick();
      chk("wr_rsp_single", rx_c1_wrvalid, 0);
      repeat (5) tick();
      drive_rd(4'h4, 32'h10, 14'h9); tick(); idle();
      repeat (6) tick();
      chk("rd_early", rx_c0_rdvalid, 0);
      tick();
      chk("rd_rsp_valid", rx_c0_rdvalid, 1);
      chk("rd_rsp_hdr", rx_c0_header, 18'h10009);
      chk("rd_rsp_data", rx_c0_data, DB);
      tick();
      chk("rd_rsp_single", rx_c0_rdvalid, 0);

      // Same-cycle read/write hazard on line 0x20
      drive_wr(4'h2, 32'h20, 14'h11, '0); tick(); idle();
      repeat (6) tick();
      drive_rd(4'h6, 32'h20, 14'h21);
      drive_wr(4'h2, 32'h20, 14'h22, '1);
      tick(); idle();
      repeat (3) tick();
      chk("haz_wr_valid", rx_c1_wrvalid, 1);
      chk("haz_wr_hdr", rx_c1_header, 18'h04022);
      repeat (4) tick();
      chk("haz_rd_valid", rx_c0_rdvalid, 1);
      chk("haz_rd_hdr", rx_c0_header, 18'h10021);
      chk("haz_rd_old", rx_c0_data, '0);
      tick();
      // 0x120 aliases line 0x20 with 256 lines
      drive_rd(4'h7, 32'h120, 14'h23); tick(); idle();
      repeat (7) tick();
      chk("alias_valid", rx_c0_rdvalid, 1);
      chk("alias_hdr", rx_c0_header, 18'h10023);
      chk("alias_new", rx_c0_data, {512{1'b1}});

      // Fence ordering
      tick();
      drive_wr(4'h2, 32'h30, 14'h1, DB);  tick();
      drive_wr(4'h2, 32'h31, 14'h2, PAT); tick();
      drive_wr(4'h5, 32'h31, 14'h3, '1);  tick(); idle();
      tick();
      chk("fence_v1", rx_c1_wrvalid, 1);
      chk("fence_m1", rx_c1_header, 18'h04001);
      tick();
      chk("fence_v2", rx_c1_wrvalid, 1);
      chk("fence_m2", rx_c1_header, 18'h04002);
      tick();
      chk("fence_v3", rx_c1_wrvalid, 1);
      chk("fence_m3", rx_c1_header, 18'h04003);
      tick();
      chk("fence_end", rx_c1_wrvalid, 0);
      drive_rd(4'h4, 32'h31, 14'h31); tick(); idle();
      repeat (7) tick();
      chk("fence_nowrite", rx_c0_data, PAT);
      chk("main_err_clean", err_flags, 0);

      // Overflow on the long-latency instance
      tick();
      for (int i = 0; i < 17; i++) begin
         ov_c0_header  = mk_hdr(4'h4, 32'(i), 14'(i));
         ov_c0_rdvalid = 1'b1;
         tick();
         if (i == 10) chk("ov_af_occ11", ov_c0_af, 0);
         if (i == 11) chk("ov_af_occ12", ov_c0_af, 1);
         if (i == 15) chk("ov_err_at_full", ov_err, 0);
      end
      ov_c0_rdvalid = 1'b0;
      chk("ov_err_set", ov_err, 4'b0001);
      chk("ov_af_full", ov_c0_af, 1);
      repeat (22) tick();
      chk("ov_none_yet", ov_cnt, 0);
      // push on a full FIFO in the cycle its head pops
      ov_c0_header  = mk_hdr(4'h4, 32'h0, 14'h77);
      ov_c0_rdvalid = 1'b1;
      tick();
      ov_c0_rdvalid = 1'b0;
      chk("ov_first_valid", ov_rdvalid, 1);
      chk("ov_first_hdr", ov_rx0_hdr, 18'h10000);
      repeat (30) tick();
      chk("ov_count16", ov_cnt, 16);
      repeat (15) tick();
      chk("ov_count17", ov_cnt, 17);
      chk("ov_order", ov_bad, 0);

      // Counter wrap
      while (cyc < 65530) tick();
      drive_rd(4'h4, 32'h10, 14'h3A); tick(); idle();
      repeat (6) tick();
      chk("wrap_early", rx_c0_rdvalid, 0);
      tick();
      chk("wrap_valid", rx_c0_rdvalid, 1);
      chk("wrap_hdr", rx_c0_header, 18'h1003A);

      // Reset with reads in flight; requests during reset and the first
      // cycle after it must be ignored
      tick();
      rc0 = rd_cnt;
      for (int i = 0; i < 3; i++) begin
         drive_rd(4'h4, 32'h10, 14'(8'h61 + i));
         tick();
      end
      drive_rd(4'h4, 32'h10, 14'h64);
      sys_reset = 1'b1;
      tick(); cyc = 0;
      chk("rst2_initdone", lp_initdone, 0);
      chk("rst2_rdvalid", rx_c0_rdvalid, 0);
      chk("rst2_ov_err", ov_err, 0);
      sys_reset = 1'b0;
      tick();
      chk("rst2_initdone_up", lp_initdone, 1);
      idle();
      repeat (20) tick();
      chk("rst2_no_rsp", rd_cnt - rc0, 0);

      // Unknown types
      wc0 = wr_cnt;
      drive_wr(4'hF, 32'h40, 14'h7F, '1); tick(); idle();
      tick();
      chk("bad1_err", err_flags, 4'b1000);
      drive_rd(4'h3, 32'h40, 14'h7E); tick(); idle();
      tick();
      chk("bad0_err", err_flags, 4'b1100);
      repeat (10) tick();
      chk("bad1_no_rsp", wr_cnt - wc0, 0);
      chk("bad0_no_rsp", rd_cnt - rc0, 0);

      // Memory survives reset
      drive_rd(4'h4, 32'h10, 14'h55); tick(); idle();
      repeat (7) tick();
      chk("post_rst_valid", rx_c0_rdvalid, 1);
      chk("post_rst_data", rx_c0_data, DB);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
